// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants, FSM state encoding and decode helper for alu_multicycle
package alu_pkg;

  // Legacy opcodes 0-7 keep their original encoding.
  localparam logic [3:0] OP_BUF_A = 4'd0;
  localparam logic [3:0] OP_NOT_A = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_NOT_B = 4'd5;
  localparam logic [3:0] OP_BUF_B = 4'd6;
  localparam logic [3:0] OP_LOW   = 4'd7;
  localparam logic [3:0] OP_SUB   = 4'd8;
  localparam logic [3:0] OP_XOR   = 4'd9;
  localparam logic [3:0] OP_SLT   = 4'd10;
  localparam logic [3:0] OP_SHL   = 4'd11;
  localparam logic [3:0] OP_SHR   = 4'd12;
  localparam logic [3:0] OP_MUL   = 4'd13;
  localparam logic [3:0] OP_DIVU  = 4'd14;
  localparam logic [3:0] OP_NOR   = 4'd15;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CALC = 1'b1;

  // Opcodes that go through the iterative datapath instead of finishing in one cycle.
  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// rtl/alu_iter_unit.sv - shift-add multiply / restoring divide datapath, one step per cycle
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             op_is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             last
);

  localparam int CW = $clog2(WIDTH) + 1;

  // hi_q: MUL accumulator / DIVU partial remainder.
  // lo_q: MUL multiplier shifting out / DIVU dividend shifting out, quotient shifting in.
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] b_q;
  logic             div_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] hi_nx;
  logic [WIDTH-1:0] lo_nx;

  // Next-step values; exposed as results so the final step lands straight in the output registers.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    div_shift = {hi_q, lo_q[WIDTH-1]};
    // The remainder is always below the divisor, so a successful trial difference fits WIDTH bits.
    div_diff  = div_shift[WIDTH-1:0] - b_q;
    div_ge    = (div_shift >= {1'b0, b_q});
    if (div_q) begin
      hi_nx = div_ge ? div_diff : div_shift[WIDTH-1:0];
      lo_nx = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      hi_nx = mul_sum[WIDTH:1];
      lo_nx = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
    res_lo = lo_nx;
    res_hi = hi_nx;
    last   = (count == CW'(1));
  end

  // Load operands on accept, then step and count down until the counter empties.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      count <= CW'(WIDTH);
      hi_q  <= '0;
      lo_q  <= a;
      b_q   <= b;
      div_q <= op_is_div;
    end else if (count != '0) begin
      count <= count - CW'(1);
      hi_q  <= hi_nx;
      lo_q  <= lo_nx;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - registered ALU with start/busy/done handshake and iterative MUL/DIVU
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       S,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             g,
  output logic             e,
  output logic             dz,
  output logic             busy,
  output logic             done
);

  logic [0:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             div_q;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_sum;
  logic [WIDTH-1:0] sc_out;
  logic             sc_cout;
  logic             sc_ovf;

  logic             iter_load;
  logic [WIDTH-1:0] iter_lo;
  logic [WIDTH-1:0] iter_hi;
  logic             iter_last;

  assign busy      = (state == ST_CALC);
  assign iter_load = start && (state == ST_IDLE) && is_iter_op(S);

  // Single-cycle result and arithmetic flags, evaluated on the inputs being accepted this edge.
  always_comb begin
    add_sum = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, cin};
    sub_sum = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
    sc_out  = '0;
    sc_cout = 1'b0;
    sc_ovf  = 1'b0;
    case (S)
      OP_BUF_A: sc_out = A;
      OP_NOT_A: sc_out = ~A;
      OP_ADD: begin
        sc_out  = add_sum[WIDTH-1:0];
        sc_cout = add_sum[WIDTH];
        sc_ovf  = (A[WIDTH-1] == B[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_OR:    sc_out = A | B;
      OP_AND:   sc_out = A & B;
      OP_NOT_B: sc_out = ~B;
      OP_BUF_B: sc_out = B;
      OP_LOW:   sc_out = '0;
      OP_SUB: begin
        sc_out  = sub_sum[WIDTH-1:0];
        sc_cout = sub_sum[WIDTH];
        sc_ovf  = (A[WIDTH-1] != B[WIDTH-1]) && (sub_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_XOR:   sc_out = A ^ B;
      OP_SLT:   sc_out = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SHL:   sc_out = A << B[SHW-1:0];
      OP_SHR:   sc_out = A >> B[SHW-1:0];
      OP_MUL:   sc_out = '0;
      OP_DIVU:  sc_out = '0;
      OP_NOR:   sc_out = ~(A | B);
      default:  sc_out = '0;
    endcase
  end

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk       (clk),
    .reset     (reset),
    .load      (iter_load),
    .op_is_div (S == OP_DIVU),
    .a         (A),
    .b         (B),
    .res_lo    (iter_lo),
    .res_hi    (iter_hi),
    .last      (iter_last)
  );

  // FSM plus result/flag registers; outputs only change on a cycle that also raises done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      out   <= '0;
      hi    <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
      g     <= 1'b0;
      e     <= 1'b0;
      dz    <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_CALC) begin
        if (iter_last) begin
          out   <= iter_lo;
          hi    <= iter_hi;
          cout  <= 1'b0;
          ovf   <= 1'b0;
          zero  <= (iter_lo == '0);
          g     <= (a_q > b_q);
          e     <= (a_q == b_q);
          dz    <= div_q && (b_q == '0);
          done  <= 1'b1;
          state <= ST_IDLE;
        end
      end else if (start) begin
        a_q   <= A;
        b_q   <= B;
        div_q <= (S == OP_DIVU);
        if (is_iter_op(S)) begin
          state <= ST_CALC;
        end else begin
          out  <= sc_out;
          hi   <= '0;
          cout <= sc_cout;
          ovf  <= sc_ovf;
          zero <= (sc_out == '0);
          g    <= (A > B);
          e    <= (A == B);
          dz   <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - self-checking bench for alu_multicycle at WIDTH=8
module tb_alu_multicycle;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] S = 4'd0;
  logic [7:0] A = 8'd0;
  logic [7:0] B = 8'd0;
  logic       cin = 1'b0;
  logic [7:0] out;
  logic [7:0] hi;
  logic       cout, ovf, zero, g, e, dz, busy, done;

  int passed = 0;
  int total  = 0;

  alu_multicycle #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .S     (S),
    .A     (A),
    .B     (B),
    .cin   (cin),
    .out   (out),
    .hi    (hi),
    .cout  (cout),
    .ovf   (ovf),
    .zero  (zero),
    .g     (g),
    .e     (e),
    .dz    (dz),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference model from the arithmetic definition of each opcode; f = {cout,ovf,zero,g,e,dz}.
  function automatic void model(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b,
                                input logic c, output logic [7:0] o, output logic [7:0] h,
                                output logic [5:0] f, output int lat);
    int ua, ub, sa, sb, r;
    logic co, ov, dzf;
    ua = a; ub = b;
    sa = int'($signed(a)); sb = int'($signed(b));
    r = 0; h = 8'd0; co = 1'b0; ov = 1'b0; dzf = 1'b0; lat = 0;
    case (s)
      4'd0:  r = ua;
      4'd1:  r = 255 - ua;
      4'd2:  begin r = ua + ub + int'(c); co = (r > 255); ov = ((sa + sb + int'(c)) > 127) || ((sa + sb + int'(c)) < -128); end
      4'd3:  r = ua | ub;
      4'd4:  r = ua & ub;
      4'd5:  r = 255 - ub;
      4'd6:  r = ub;
      4'd7:  r = 0;
      4'd8:  begin r = ua - ub; co = (ua >= ub); ov = ((sa - sb) > 127) || ((sa - sb) < -128); end
      4'd9:  r = ua ^ ub;
      4'd10: r = (sa < sb) ? 1 : 0;
      4'd11: r = ua << (ub % 8);
      4'd12: r = ua >> (ub % 8);
      4'd13: begin r = ua * ub; h = 8'((ua * ub) / 256); lat = 8; end
      4'd14: begin
        lat = 8;
        if (ub == 0) begin r = 255; h = a; dzf = 1'b1; end
        else begin r = ua / ub; h = 8'(ua % ub); end
      end
      default: r = 255 - (ua | ub);
    endcase
    o = r[7:0];
    f = {co, ov, (o == 8'd0), (ua > ub), (ua == ub), dzf};
  endfunction

  task automatic do_op(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b,
                       input logic c, output int lat);
    @(negedge clk);
    S = s; A = a; B = b; cin = c; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = ~a; B = ~b; S = 4'd7;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_op(input string tag, input logic [3:0] s, input logic [7:0] a,
                          input logic [7:0] b, input logic c);
    logic [7:0] eo, eh;
    logic [5:0] ef;
    int el, lat;
    model(s, a, b, c, eo, eh, ef, el);
    do_op(s, a, b, c, lat);
    chk({tag, "_lat"}, lat, el);
    chk({tag, "_out"}, out, eo);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_flags"}, {cout, ovf, zero, g, e, dz}, ef);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int lat;
    int seen_done;
    logic [3:0] rs;
    logic [7:0] ra, rb;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", out, 8'h00);
    chk("rst_hi", hi, 8'h00);
    chk("rst_flags", {cout, ovf, zero, g, e, dz, busy, done}, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    // ADD with carry-in
    check_op("add", 4'd2, 8'hF0, 8'h20, 1'b1);
    chk("add_out_const", out, 8'h11);
    chk("add_flags_const", {cout, ovf, g, e}, 4'b1010);

    // SUB with signed overflow and borrow
    check_op("sub", 4'd8, 8'h7F, 8'h80, 1'b0);
    chk("sub_const", {out, cout, ovf}, {8'hFF, 1'b0, 1'b1});

    check_op("slt", 4'd10, 8'h80, 8'h01, 1'b0);
    chk("slt_const", out, 8'h01);
    check_op("shr", 4'd12, 8'h80, 8'h03, 1'b0);
    chk("shr_const", out, 8'h10);

    // MUL with a start pulse while busy that must be dropped
    @(negedge clk);
    S = 4'd13; A = 8'hFF; B = 8'hFF; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("mul_busy", busy, 1'b1);
    @(negedge clk);
    S = 4'd2; A = 8'h01; B = 8'h01; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = 8'h12; B = 8'h34;
    lat = 1;
    chk("mul_out_held", out, 8'h10);
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("mul_lat", lat, 8);
    chk("mul_result", {hi, out}, 16'hFE01);
    @(posedge clk);
    #1;
    chk("mul_ignored_start", {done, busy, hi, out}, {2'b00, 16'hFE01});

    check_op("divu", 4'd14, 8'h64, 8'h07, 1'b0);
    chk("divu_const", {out, hi}, 16'h0E02);
    check_op("divz", 4'd14, 8'h2A, 8'h00, 1'b0);
    chk("divz_const", {out, hi, dz}, {16'hFF2A, 1'b1});

    // Asynchronous reset mid-MUL discards the operation
    @(negedge clk);
    S = 4'd13; A = 8'hFF; B = 8'hFF; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_out", {out, hi}, 16'h0000);
    chk("midrst_flags", {cout, ovf, zero, g, e, dz, busy, done}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    chk("midrst_no_done", seen_done, 0);
    check_op("post_rst_add", 4'd2, 8'h01, 8'h01, 1'b0);
    chk("post_rst_add_const", out, 8'h02);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      rs = 4'($urandom_range(0, 15));
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 7) == 0) rb = 8'h00;
      if ($urandom_range(0, 7) == 0) rb = ra;
      check_op("rnd", rs, ra, rb, 1'($urandom));
    end

    // Back-to-back single-cycle ops
    @(negedge clk);
    S = 4'd3; A = 8'hF0; B = 8'h0F; start = 1'b1;
    @(posedge clk);
    #1;
    chk("b2b_or", {done, out}, {1'b1, 8'hFF});
    @(negedge clk);
    S = 4'd4;
    @(posedge clk);
    #1;
    chk("b2b_and", {done, out, zero}, {1'b1, 8'h00, 1'b1});
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b_done_drop", done, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
